// File: rtl/rom_stats_engine_pkg.sv
// Shared types and constants for the ROM statistics engine.
// Optional sum-of-squares / variance path: define ROM_STATS_VARIANCE_EN.
package dsp_stats_pkg;

  // CALC2 is only entered when the variance path is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    CALC  = 3'd3,
    CALC2 = 3'd4,
    DONE  = 3'd5
  } stats_state_t;

  // Extremes of the 32-bit two's complement sample word held in the ROM.
  localparam int SAMPLE_WIDTH = 32;
  localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MOST_POS = 32'sh7FFF_FFFF;
  localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MOST_NEG = 32'sh8000_0000;

  // Sum width that cannot overflow for num_samples samples of data_width bits.
  function automatic int calc_acc_width(input int data_width, input int num_samples);
    return data_width + $clog2(num_samples);
  endfunction

endpackage

// File: rtl/rom_stats_engine_if.sv
// ROM read port seen from the statistics engine.
// Optional feature macro: ROM_STATS_VARIANCE_EN (does not change this bus).
// There is no valid/ready pair: the engine drives one address per cycle and the
// ROM returns that word exactly one clock later (registered read).
interface rom_stats_engine_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH_BITS = 9
);
  logic        [ADDR_WIDTH_BITS-1:0] rom_addr_o;
  logic signed [DATA_WIDTH-1:0]      rom_data_i;

  modport master (output rom_addr_o, input rom_data_i);
  modport slave  (input rom_addr_o, output rom_data_i);
endinterface

// File: rtl/rom_stats_engine_accumulator.sv
// Running sum / min / max over the samples of one pass.
// With ROM_STATS_VARIANCE_EN defined, also a sum of squares behind one
// registered multiplier stage.
module stats_accumulator
  import dsp_stats_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ACC_WIDTH   = calc_acc_width(32, 512),
  parameter int SUMSQ_WIDTH = 2*DATA_WIDTH + 9
)(
  input  logic                         sys_clock,
  input  logic                         sys_reset,
  input  logic                         clear,
  input  logic                         valid,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [ACC_WIDTH-1:0]  sum,
  output logic signed [DATA_WIDTH-1:0] min_val,
  output logic signed [DATA_WIDTH-1:0] max_val
`ifdef ROM_STATS_VARIANCE_EN
  ,
  output logic [SUMSQ_WIDTH-1:0]       sumsq
`endif
);

  localparam logic signed [DATA_WIDTH-1:0] INIT_MIN = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] INIT_MAX = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] sample_ext;
  assign sample_ext = {{(ACC_WIDTH-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};

  // Sum and signed extremes; clear seeds min/max so the first sample wins.
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      sum     <= '0;
      min_val <= '0;
      max_val <= '0;
    end else if (clear) begin
      sum     <= '0;
      min_val <= INIT_MIN;
      max_val <= INIT_MAX;
    end else if (valid) begin
      sum <= sum + sample_ext;
      if (sample < min_val) min_val <= sample;
      if (sample > max_val) max_val <= sample;
    end
  end

`ifdef ROM_STATS_VARIANCE_EN
  logic signed [2*DATA_WIDTH-1:0] sq_in;
  logic        [2*DATA_WIDTH-1:0] sq_q;
  logic                           sq_vld_q;
  assign sq_in = {{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample};

  // Square is registered first, so the sum of squares trails by one cycle.
  always_ff @(posedge sys_clock) begin
    if (sys_reset || clear) begin
      sq_q     <= '0;
      sq_vld_q <= 1'b0;
      sumsq    <= '0;
    end else begin
      sq_q     <= sq_in * sq_in;
      sq_vld_q <= valid;
      if (sq_vld_q) sumsq <= sumsq + {{(SUMSQ_WIDTH-2*DATA_WIDTH){1'b0}}, sq_q};
    end
  end
`endif

endmodule

// File: rtl/rom_stats_engine.sv
// Walks ROM addresses 0..NUM_SAMPLES-1, absorbs the 1-cycle read latency and
// publishes sum / mean / min / max with a one-cycle done pulse.
// Optional feature macro: ROM_STATS_VARIANCE_EN adds sumsq_o and variance_o.
module rom_stats_engine
  import dsp_stats_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ROM_DEPTH       = 512,
  parameter int ADDR_WIDTH_BITS = $clog2(ROM_DEPTH),
  parameter int NUM_SAMPLES     = 512,
  parameter int LOG2_N          = $clog2(NUM_SAMPLES),
  parameter int ACC_WIDTH       = calc_acc_width(DATA_WIDTH, NUM_SAMPLES)
)(
  input  logic                         sys_clock,
  input  logic                         sys_reset,
  input  logic                         start_i,
  rom_stats_engine_if.master           rom_bus,
  output logic                         busy_o,
  output logic                         done_o,
  output logic signed [ACC_WIDTH-1:0]  sum_o,
  output logic signed [DATA_WIDTH-1:0] mean_o,
  output logic signed [DATA_WIDTH-1:0] min_o,
  output logic signed [DATA_WIDTH-1:0] max_o,
  output stats_state_t                 state_o
`ifdef ROM_STATS_VARIANCE_EN
  ,
  output logic [2*DATA_WIDTH+LOG2_N-1:0] sumsq_o,
  output logic [2*DATA_WIDTH-1:0]        variance_o
`endif
);

  generate
    if (NUM_SAMPLES < 2 || NUM_SAMPLES > ROM_DEPTH ||
        (NUM_SAMPLES & (NUM_SAMPLES - 1)) != 0) begin : g_bad_num_samples
      $error("rom_stats_engine: NUM_SAMPLES must be a power of two in 2..ROM_DEPTH");
    end
    if (ACC_WIDTH != DATA_WIDTH + LOG2_N) begin : g_bad_acc_width
      $error("rom_stats_engine: ACC_WIDTH must equal DATA_WIDTH + LOG2_N");
    end
  endgenerate

  localparam logic [ADDR_WIDTH_BITS-1:0] LAST_ADDR = ADDR_WIDTH_BITS'(NUM_SAMPLES - 1);
  localparam logic [ADDR_WIDTH_BITS-1:0] ADDR_ONE  = ADDR_WIDTH_BITS'(1);

  stats_state_t                state_q, state_d;
  logic [ADDR_WIDTH_BITS-1:0]  addr_q, addr_d;
  logic                        rd_vld_q;
  logic                        acc_clear;
  logic                        calc_en;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [DATA_WIDTH-1:0] acc_min, acc_max;
`ifdef ROM_STATS_VARIANCE_EN
  logic                        calc2_phase_q;
  logic [2*DATA_WIDTH+LOG2_N-1:0] acc_sumsq;
`endif

  stats_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SUMSQ_WIDTH(2*DATA_WIDTH + LOG2_N)
  ) u_acc (
    .sys_clock(sys_clock),
    .sys_reset(sys_reset),
    .clear    (acc_clear),
    .valid    (rd_vld_q),
    .sample   (rom_bus.rom_data_i),
    .sum      (acc_sum),
    .min_val  (acc_min),
    .max_val  (acc_max)
`ifdef ROM_STATS_VARIANCE_EN
    ,
    .sumsq    (acc_sumsq)
`endif
  );

  assign rom_bus.rom_addr_o = addr_q;
  assign state_o            = state_q;
  assign busy_o             = (state_q != IDLE) && (state_q != DONE);
  assign done_o             = (state_q == DONE);

  // State, address counter and the read-valid pipe that tracks ROM latency.
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_vld_q <= (state_q == READ);
    end
  end

  // Next state; the address saturates at the last sample and is reset on exit.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    acc_clear = 1'b0;
    calc_en   = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start_i) begin
          state_d   = READ;
          acc_clear = 1'b1;
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) state_d = DRAIN;
        else                     addr_d  = addr_q + ADDR_ONE;
      end
      DRAIN: state_d = CALC;
      CALC: begin
        calc_en = 1'b1;
`ifdef ROM_STATS_VARIANCE_EN
        state_d = CALC2;
`else
        state_d = DONE;
`endif
      end
      CALC2: begin
`ifdef ROM_STATS_VARIANCE_EN
        if (calc2_phase_q) state_d = DONE;
`else
        state_d = DONE;
`endif
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers: loaded once per pass, held until the next CALC.
  // The mean is the sum shifted right by LOG2_N, i.e. its upper DATA_WIDTH bits.
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      sum_o  <= '0;
      mean_o <= '0;
      min_o  <= '0;
      max_o  <= '0;
    end else if (calc_en) begin
      sum_o  <= acc_sum;
      mean_o <= acc_sum[ACC_WIDTH-1:LOG2_N];
      min_o  <= acc_min;
      max_o  <= acc_max;
    end
  end

`ifdef ROM_STATS_VARIANCE_EN
  logic signed [2*DATA_WIDTH-1:0] mean_ext;
  logic        [2*DATA_WIDTH-1:0] mean_sq_q;
  logic        [2*DATA_WIDTH-1:0] sumsq_div;
  assign mean_ext  = {{DATA_WIDTH{mean_o[DATA_WIDTH-1]}}, mean_o};
  assign sumsq_div = sumsq_o[2*DATA_WIDTH+LOG2_N-1:LOG2_N];

  // Two CALC2 cycles: square the mean and latch sumsq, then subtract with floor at 0.
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      calc2_phase_q <= 1'b0;
      mean_sq_q     <= '0;
      sumsq_o       <= '0;
      variance_o    <= '0;
    end else if (state_q == CALC2) begin
      if (!calc2_phase_q) begin
        sumsq_o       <= acc_sumsq;
        mean_sq_q     <= mean_ext * mean_ext;
        calc2_phase_q <= 1'b1;
      end else begin
        variance_o    <= (sumsq_div > mean_sq_q) ? (sumsq_div - mean_sq_q) : '0;
        calc2_phase_q <= 1'b0;
      end
    end
  end
`endif

endmodule
